// File: rtl/mdu_defs.sv
// Shared MDU definitions: op codes, FSM state encoding, result payload and
// the arithmetic helper used by the multiply/divide datapath.
package mdu_defs;

   localparam int unsigned XLEN = 32;

   // Op codes shared with ControllerE and hazardunit
   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } mdu_op_t;

   // MDU sequencing states
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_t;

   // HI/LO pair; hi occupies the upper half of the packed vector
   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } mdu_result_t;

   // Ops that occupy the unit for a multi-cycle busy window
   function automatic logic is_mult(input logic [2:0] op);
      return (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   function automatic logic is_div(input logic [2:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

   // Full 64-bit HI/LO result for a multiply or divide op.
   // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly
   // to 0x80000000 with a zero remainder instead of overflowing.
   function automatic mdu_result_t mdu_calc(input logic [2:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
      logic [2*XLEN-1:0] prod;
      logic [XLEN-1:0]   ua;
      logic [XLEN-1:0]   ub;
      logic [XLEN-1:0]   q;
      logic [XLEN-1:0]   r;
      mdu_result_t       res;
      prod = '0;
      ua   = a;
      ub   = b;
      q    = '0;
      r    = '0;
      res  = '0;
      case (op)
         OP_MULT: begin
            prod = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
            res  = mdu_result_t'(prod);
         end
         OP_MULTU: begin
            prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
            res  = mdu_result_t'(prod);
         end
         OP_DIV: begin
            ua = a[XLEN-1] ? XLEN'(-a) : a;
            ub = b[XLEN-1] ? XLEN'(-b) : b;
            if (ub != '0) begin
               q = ua / ub;
               r = ua % ub;
            end
            res.lo = (a[XLEN-1] ^ b[XLEN-1]) ? XLEN'(-q) : q;
            res.hi = a[XLEN-1] ? XLEN'(-r) : r;
         end
         OP_DIVU: begin
            if (ub != '0) begin
               q = ua / ub;
               r = ua % ub;
            end
            res.lo = q;
            res.hi = r;
         end
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Operands are latched at start;
// the result is computed from the latched copy and committed to HI/LO on the
// same edge that busy falls.
module mdu
   import mdu_defs::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   // A zero or negative count would leave no busy window; force at least one
   localparam int unsigned MULT_N = (MULT_CYCLES < 1) ? 1 : MULT_CYCLES;
   localparam int unsigned DIV_N  = (DIV_CYCLES  < 1) ? 1 : DIV_CYCLES;
   localparam int unsigned MAX_N  = (MULT_N > DIV_N) ? MULT_N : DIV_N;
   localparam int unsigned CNT_W  = $clog2(MAX_N + 1);

   mdu_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       op_q;
   logic [XLEN-1:0]  a_q;
   logic [XLEN-1:0]  b_q;
   mdu_result_t      res_c;
   logic             div_zero_c;

   // Result from latched operands; divide by zero suppresses the HI/LO write
   always_comb begin
      res_c      = mdu_calc(op_q, a_q, b_q);
      div_zero_c = is_div(op_q) && (b_q == '0);
   end

   // Sequencer: accept ops in IDLE, count down in BUSY, commit on exit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         op_q  <= 3'(OP_NONE);
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (is_mult(op) || is_div(op)) begin
                     op_q  <= op;
                     a_q   <= a;
                     b_q   <= b;
                     cnt   <= is_mult(op) ? CNT_W'(MULT_N) : CNT_W'(DIV_N);
                     busy  <= 1'b1;
                     state <= ST_BUSY;
                  end else if (op == OP_MTHI) begin
                     hi <= a;
                  end else if (op == OP_MTLO) begin
                     lo <= a;
                  end
               end
            end
            ST_BUSY: begin
               if (cnt <= CNT_W'(1)) begin
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
                  if (!div_zero_c) begin
                     hi <= res_c.hi;
                     lo <= res_c.lo;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: stimulus pushes expected HI/LO and busy length,
// a negedge monitor pops and compares whenever busy drops.
module tb_mdu;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          len;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   bcount = 0;

   mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] h, input logic [31:0] l, input int len);
      exp_t e;
      e.hi  = h;
      e.lo  = l;
      e.len = len;
      exp_q.push_back(e);
   endtask

   // One-cycle start pulse, sampled at the next rising edge
   task automatic pulse(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(posedge clk); #1;
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      @(posedge clk); #1;
      start = 1'b0;
      op    = 3'd0;
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      chk(name, 32'(done), 32'd1);
   endtask

   // Monitor: count busy cycles and compare when the operation completes
   always @(negedge clk) begin
      if (reset) begin
         bcount = 0;
      end else if (busy) begin
         bcount++;
      end else if (bcount != 0) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result: got hi %h lo %h expected none", hi, lo);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_hi", hi, e.hi);
            chk("sb_lo", lo, e.lo);
            chk("sb_busy_len", 32'(bcount), 32'(e.len));
         end
         bcount = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 3'd0;
      a     = '0;
      b     = '0;
      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Multiply / divide directed vectors
      push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
      pulse(3'd1, 32'hFFFFFFFE, 32'd3);
      wait_idle("mult_done");

      push(32'hFFFFFFFE, 32'h00000001, 5);
      pulse(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_idle("multu_done");

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      pulse(3'd3, 32'hFFFFFFF9, 32'd2);
      wait_idle("div_done");

      push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      pulse(3'd4, 32'd7, 32'd0);
      wait_idle("divu_zero_done");

      push(32'h00000000, 32'h80000000, 10);
      pulse(3'd3, 32'h80000000, 32'hFFFFFFFF);
      wait_idle("div_ovf_done");

      push(32'h00000001, 32'hFFFFFFFD, 10);
      pulse(3'd3, 32'd7, 32'hFFFFFFFE);
      wait_idle("div_negb_done");

      // MTHI / MTLO write without busy
      pulse(3'd5, 32'h12345678, 32'd0);
      chk("mthi_hi", hi, 32'h12345678);
      chk("mthi_lo_kept", lo, 32'hFFFFFFFD);
      chk("mthi_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("mthi_busy_later", 32'(busy), 32'd0);

      pulse(3'd6, 32'hAABBCCDD, 32'd0);
      chk("mtlo_lo", lo, 32'hAABBCCDD);
      chk("mtlo_hi_kept", hi, 32'h12345678);

      // Starts while busy are ignored
      push(32'd2, 32'd14, 10);
      pulse(3'd4, 32'd100, 32'd7);
      pulse(3'd6, 32'hDEADBEEF, 32'd0);
      pulse(3'd1, 32'd2, 32'd2);
      wait_idle("busy_ignore_done");

      // Operands wiggle during BUSY; latched values must be used
      push(32'd0, 32'h00300000, 5);
      pulse(3'd2, 32'h00010000, 32'h00000030);
      repeat (3) begin
         a = $urandom;
         b = $urandom;
         @(posedge clk); #1;
      end
      wait_idle("latch_done");

      // Reset mid-way through cycle 3 of a DIV aborts it
      pulse(3'd5, 32'h5555AAAA, 32'd0);
      pulse(3'd3, 32'd1000, 32'd10);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("abort_no_write_hi", hi, 32'd0);
      chk("abort_no_write_lo", lo, 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);

      // First start accepted on the first edge after reset release
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b1;
      op    = 3'd1;
      a     = 32'd5;
      b     = 32'hFFFFFFFD;
      push(32'hFFFFFFFF, 32'hFFFFFFF1, 5);
      @(posedge clk); #1;
      start = 1'b0;
      op    = 3'd0;
      chk("first_start_busy", 32'(busy), 32'd1);
      wait_idle("first_start_done");

      repeat (3) @(posedge clk);
      #1;
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, giving the busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, giving the busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: E-stage pulse requesting the operation in op.
REQ-006 The block SHALL have port op, input, 3 bits: operation code.
REQ-007 The block SHALL have port a, input, 32 bits: forwarded rs value from E stage.
REQ-008 The block SHALL have port b, input, 32 bits: forwarded rt value from E stage.
REQ-009 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-010 The block SHALL have port hi, output, 32 bits: HI register, read by MFHI in E stage.
REQ-011 The block SHALL have port lo, output, 32 bits: LO register, read by MFLO in E stage.

Function
REQ-012 The op encoding SHALL be: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6; codes 7 and NONE are no-ops.
REQ-013 The FSM SHALL have states IDLE and BUSY with a down-counter cnt.
REQ-014 In IDLE, start with op MULT/MULTU/DIV/DIVU SHALL latch a, b and op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter BUSY at that edge.
REQ-015 busy SHALL be high exactly N cycles after the start edge (N = the loaded count) and low otherwise.
REQ-016 HI/LO SHALL update at the same edge busy falls, so results are visible the first cycle busy is low.
REQ-017 MULT SHALL produce the signed 64-bit product {hi,lo}; MULTU the unsigned 64-bit product.
REQ-018 DIV SHALL give lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-019 DIVU SHALL give lo = unsigned quotient and hi = unsigned remainder.
REQ-020 DIV/DIVU with b == 0 SHALL still run DIV_CYCLES and leave hi and lo unchanged.
REQ-021 DIV with a=0x80000000 and b=0xFFFFFFFF SHALL give lo=0x80000000 and hi=0.
REQ-022 MTHI/MTLO with start in IDLE SHALL write a into hi/lo at the next edge, without asserting busy.
REQ-023 start while busy, for any op, SHALL be ignored; the hazard unit stalls D to prevent it.
REQ-024 Latched operands SHALL be used; a/b changes during BUSY SHALL NOT affect the result.
REQ-025 The stall contract SHALL be: the hazard unit stalls any MD instruction in D while (start or busy) is true.

Reset
REQ-026 Asserting reset SHALL force state IDLE, cnt=0, busy=0, hi=0 and lo=0 immediately, without waiting for clk.
REQ-027 Reset during BUSY SHALL abort the operation, with no HI/LO write after deassertion.
REQ-028 The first start SHALL be accepted at the first rising edge after reset deasserts.

Structure
REQ-029 Op codes and the state encoding SHALL reside in a shared package/include (mdu_defs) shared with ControllerE and hazardunit.
REQ-030 The block SHALL be one module; the datapath is either a combinational multiply/divide captured at start and delayed, or iterative, provided REQ-015/016 timing holds.
REQ-031 No sub-module is required; an optional divider core SHALL be named mdu_div.

Verification
REQ-032 MULT with a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
REQ-034 DIV with a=-7, b=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 -> hi/lo unchanged.
REQ-035 MTHI with a=0x12345678 -> next cycle hi=0x12345678, busy stays 0; MTLO issued during DIV BUSY -> ignored, lo equals the DIV result.
REQ-036 Reset asserted mid-cycle in cycle 3 of DIV -> busy, hi and lo go to 0 before the next edge, and no later write occurs.
REQ-037 Operands a/b changed every cycle during MULT BUSY -> result equals the product of the values at start.
